// File: rtl/main_memory_ctrl.sv
// Line-granular backing memory with fixed-latency request/ready handshake.
// Optional MEM_ALIGN_CHECK_EN flags misaligned/out-of-range/dual-op requests.
module main_memory_ctrl #(
    parameter int CACHE_LINE_SIZE = 128,
    parameter int MEM_LINES       = 1024,
    parameter int LATENCY         = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_mem_read_en,
    input  logic                       in_mem_write_en,
    input  logic [31:0]                in_mem_addr,
    input  logic [CACHE_LINE_SIZE-1:0] in_mem_write_data,
    output logic [CACHE_LINE_SIZE-1:0] out_mem_read_data,
    output logic                       out_mem_ready,
    output logic                       out_busy,
    output logic                       out_error
);

    localparam int OFF = $clog2(CACHE_LINE_SIZE / 8);
    localparam int IDX = $clog2(MEM_LINES);
    localparam int CW  = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [IDX-1:0]             idx_q, idx_d;
    logic [CACHE_LINE_SIZE-1:0] wdata_q, wdata_d;
    logic [CACHE_LINE_SIZE-1:0] rdata_q, rdata_d;
    logic                       wr_q, wr_d;
    logic [CACHE_LINE_SIZE-1:0] rline;
    logic                       req;
    logic                       resp;
    logic                       bad;

    // Array is zero at time 0 and deliberately untouched by reset.
    logic [CACHE_LINE_SIZE-1:0] mem [MEM_LINES] = '{default: '0};

    assign req   = in_mem_read_en | in_mem_write_en;
    assign resp  = (state_q == RESP);
    assign rline = bad ? '0 : mem[idx_q];

`ifdef MEM_ALIGN_CHECK_EN
    logic bad_q, bad_d;
    logic err_q, err_d;

    assign bad       = bad_q;
    assign out_error = resp & err_q;

    // Classify the request when it is accepted; the flags ride with it.
    always_comb begin
        bad_d = bad_q;
        err_d = err_q;
        if (state_q == IDLE && req) begin
            bad_d = (in_mem_addr[OFF-1:0] != '0) ||
                    ((in_mem_addr >> (OFF + IDX)) != 32'd0);
            err_d = bad_d || (in_mem_read_en && in_mem_write_en);
        end
    end

    // Error flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            bad_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            bad_q <= bad_d;
            err_q <= err_d;
        end
    end
`else
    logic unused_addr;

    assign bad         = 1'b0;
    assign out_error   = 1'b0;
    assign unused_addr = ^in_mem_addr;
`endif

    // Next-state: latch request in IDLE, count down in WAIT, answer in RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = in_mem_addr[OFF+IDX-1:OFF];
                    wdata_d = in_mem_write_data;
                    wr_d    = in_mem_write_en;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CW'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                if (!wr_q) rdata_d = rline;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    // Commit a write on the edge that ends RESP; reset discards it.
    always_ff @(posedge clk) begin
        if (!reset && resp && wr_q && !bad) mem[idx_q] <= wdata_q;
    end

    assign out_mem_ready     = resp;
    assign out_busy          = (state_q != IDLE);
    assign out_mem_read_data = (resp && !wr_q) ? rline : rdata_q;

endmodule
